// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter for one UART tx; req_valid/last/data/ready per requester, data_tx/txEn/txDone to the tx, grant_id/busy/timeout_err status
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 txDone,
  output logic [7:0]           data_tx,
  output logic                 txEn,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t state;
  logic [ID_W-1:0] rr_ptr, winner, next_ptr;
  logic [WD_W-1:0] watchdog;
  logic last_flag;
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return ID_W'(s >= NUM_REQ ? s - NUM_REQ : s);
  endfunction
  always_comb begin
    winner = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[rr_idx(rr_ptr, i)]) winner = rr_idx(rr_ptr, i);
  end
  assign next_ptr  = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
  assign req_ready = (state == SEND) ? NUM_REQ'(1) << grant_id : '0;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      data_tx     <= '0;
      txEn        <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      watchdog    <= '0;
      last_flag   <= 1'b0;
    end else begin
      txEn <= 1'b0;
      case (state)
        IDLE:
          if (|req_valid) begin
            grant_id <= winner;
            state    <= SEND;
          end
        SEND:
          if (req_valid[grant_id]) begin
            data_tx   <= req_data[{grant_id, 3'b000} +: 8];
            last_flag <= req_last[grant_id];
            txEn      <= 1'b1;
            watchdog  <= '0;
            state     <= WAIT;
          end
        WAIT:
          if (txDone) begin
            state <= last_flag ? IDLE : SEND;
            if (last_flag) rr_ptr <= next_ptr;
          end else if (watchdog == WD_W'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            rr_ptr      <= next_ptr;
            state       <= IDLE;
          end else
            watchdog <= watchdog + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized requesters and UART against a packet-level reference model
module tb_uart_tx_arbiter;
  localparam int N = 4, IW = 2, T = 16;
  logic clk = 0, reset = 1, txDone = 0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] data_tx;
  logic txEn, busy, timeout_err;
  logic [IW-1:0] grant_id;
  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .txDone(txDone), .data_tx(data_tx), .txEn(txEn), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  logic [7:0] qd [N][$];
  bit ql [N][$];
  int owner, ptr, sent_cyc, done_at, cyc = 0, e_gid;
  bit inflight, cur_last, e_txen, e_to;
  logic [7:0] e_data;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset;
    owner = -1; ptr = 0; inflight = 0; cur_last = 0; e_txen = 0; e_to = 0;
    e_data = '0; e_gid = 0; done_at = -1; sent_cyc = 0;
  endtask
  task automatic model_step;
    cyc++;
    e_txen = 0;
    if (owner < 0) begin
      for (int k = N - 1; k >= 0; k--)
        if (req_valid[(ptr + k) % N]) owner = (ptr + k) % N;
      if (owner >= 0) e_gid = owner;
    end else if (!inflight) begin
      if (req_valid[owner]) begin
        e_data = req_data[8*owner +: 8];
        cur_last = req_last[owner];
        e_txen = 1;
        inflight = 1;
        sent_cyc = cyc;
        void'(qd[owner].pop_front());
        void'(ql[owner].pop_front());
        done_at = ($urandom_range(0, 7) == 0) ? -1 : cyc + int'($urandom_range(0, 8));
      end
    end else if (txDone) begin
      inflight = 0;
      if (cur_last) begin
        ptr = (owner + 1) % N;
        owner = -1;
      end
    end else if (cyc - sent_cyc == T) begin
      e_to = 1;
      inflight = 0;
      ptr = (owner + 1) % N;
      owner = -1;
    end
  endtask
  task automatic compare;
    logic [N-1:0] exp_rdy;
    exp_rdy = '0;
    if (owner >= 0 && !inflight) exp_rdy[owner] = 1'b1;
    chk("busy", busy, owner >= 0);
    chk("req_ready", req_ready, exp_rdy);
    chk("txEn", txEn, e_txen);
    chk("grant_id", grant_id, e_gid);
    chk("timeout_err", timeout_err, e_to);
    chk("data_tx", data_tx, e_data);
  endtask
  task automatic drive;
    for (int i = 0; i < N; i++) begin
      if (qd[i].size() == 0) begin
        int len;
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          qd[i].push_back(8'($urandom));
          ql[i].push_back(j == len - 1);
        end
      end
      req_valid[i] = $urandom_range(0, 3) != 0;
      req_data[8*i +: 8] = qd[i][0];
      req_last[i] = ql[i][0];
    end
    txDone = (cyc == done_at) || ($urandom_range(0, 19) == 0);
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step;
      #1;
      compare;
      drive;
    end
  endtask
  initial begin
    model_reset;
    repeat (3) @(posedge clk);
    #1;
    compare;
    reset = 0;
    drive;
    run(3000);
    for (int i = 0; i < 200 && !inflight; i++) run(1);
    chk("reach_wait", inflight, 1);
    @(negedge clk);
    #2 reset = 1;
    #1;
    model_reset;
    compare;
    @(posedge clk);
    #1;
    compare;
    reset = 0;
    drive;
    run(2000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte-stream requesters, such as per-core memory-dump controllers. Arbitration is round-robin at packet granularity. Once a requester is granted, it keeps the transmitter until it delivers a byte flagged last. The block issues one txEn pulse per byte, waits for the transmitter's txDone, and releases a hung transfer after a watchdog timeout.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NUM_REQ
TIMEOUT_CYC, 100000, clk cycles allowed between txEn and txDone before forced release

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  requester i has a byte on its data slice
req_last  input  NUM_REQ  the byte from requester i is the final byte of its packet
req_data  input  8*NUM_REQ  byte from requester i on bits [8i+7:8i]
req_ready  output  NUM_REQ  byte from requester i is accepted this cycle
txDone  input  1  one-cycle pulse from the UART transmitter: byte finished
data_tx  output  8  byte presented to the transmitter
txEn  output  1  one-cycle pulse that starts transmission of data_tx
grant_id  output  ID_W  index of the current/last granted requester
busy  output  1  high while a packet is in progress (state != IDLE)
timeout_err  output  1  sticky; set on watchdog expiry, cleared only by reset

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Assertion forces state to IDLE regardless of where the operation is.
- Reset values: data_tx=0, txEn=0, req_ready=0, grant_id=0, busy=0, timeout_err=0, rr_ptr=0, watchdog=0, last_flag=0.
- States: IDLE, SEND, WAIT.
- IDLE:
  - If any req_valid bit is set, select the winner: the first index at or after rr_ptr, searching upward with wrap modulo NUM_REQ.
  - grant_id <= winner, state <= SEND.
  - No byte is accepted in IDLE; req_ready=0.
- SEND:
  - req_ready is combinational: req_ready[grant_id] = 1, all other bits 0.
  - On an edge where req_valid[grant_id]=1:
    - data_tx <= that requester's byte slice.
    - last_flag <= req_last[grant_id].
    - txEn <= 1 for exactly one cycle.
    - watchdog <= 0; state <= WAIT.
  - If req_valid[grant_id]=0, stay in SEND and keep the grant. Valid from other requesters is ignored; there is no pre-emption.
- WAIT:
  - req_ready=0; watchdog increments every cycle.
  - txDone is sampled only in WAIT. Because WAIT is entered the cycle after the txEn edge, a txDone coincident with txEn is ignored.
  - On txDone with last_flag=1: rr_ptr <= (grant_id+1) mod NUM_REQ, state <= IDLE.
  - On txDone with last_flag=0: state <= SEND. The next byte can therefore be accepted no earlier than 1 cycle after txDone.
  - If watchdog reaches TIMEOUT_CYC-1 without txDone: timeout_err <= 1, rr_ptr <= grant_id+1 (wrapping), state <= IDLE. The rest of the packet is abandoned, and the requester sees its next byte only when granted again.
- txDone received in IDLE or SEND is ignored and has no side effect.
- data_tx holds its value until the next accepted byte; it is not cleared between bytes.
- grant_id holds its last value in IDLE.
- busy = (state != IDLE), combinational.
- Round-robin wrap: after index NUM_REQ-1 the search continues at index 0.
- Throughput per byte (transmitter latency L cycles from txEn to txDone): L+2 cycles. The components are 1 cycle SEND accept, L cycles WAIT, and 1 cycle return to SEND, assuming valid is already high.
- Simultaneous events:
  - A requester raising req_valid in the same cycle another's packet ends competes in the IDLE cycle that follows.
  - If only the just-finished requester is valid, it is re-granted; there is no idle penalty beyond the IDLE cycle.

Test Plan:
1. Single packet: reset; req_valid[0]=1 with bytes 0x01..0x08 and last on 0x08; txDone 5 cycles after each txEn -> 8 txEn pulses with data_tx 0x01..0x08 in order, busy falls after the final txDone, rr_ptr=1.
2. Round-robin: req_valid[0] and req_valid[2] both held high, each sending 2-byte packets (0xA0/0xA1 and 0xC0/0xC1) -> grant_id sequence is 0,2,0,2; no byte interleaving between packets.
3. Wrap-around: rr_ptr=3 (after a req 2 packet), then req 0 and req 3 valid together -> req 3 is granted first, then req 0.
4. Stall and spurious txDone: granted req 1 drops valid for 10 cycles mid-packet while req 2 is valid; txDone pulsed in SEND -> grant stays 1, no txEn and no state change, transfer resumes when req 1 valid returns.
5. Watchdog: TIMEOUT_CYC=16; byte 0x55 sent with no txDone -> 16 cycles after txEn, timeout_err=1, state=IDLE, the next requester is granted; timeout_err stays 1 until reset.
6. Reset mid-operation: assert reset asynchronously during WAIT (between clock edges) -> txEn, busy and req_ready drop immediately, grant_id=0, timeout_err=0; after release, the first valid requester from index 0 is granted.
